// File: rtl/multiply_const_pipe_if.sv
// Stream interface for multiply_const_pipe.
// Handshake: a beat moves on a rising clk edge when valid && ready are both
// high on that edge; the producer keeps valid and data stable until the beat
// moves, and ready may depend combinationally on the consumer side.
interface multiply_const_pipe_if #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 30
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  x;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
    logic             sat;

    // Upstream producer and downstream consumer seen together from outside.
    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y, sat
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y, sat
    );
endinterface

// File: rtl/multiply_const_pipe.sv
// Three-stage unsigned multiply-by-constant with fixed-point shift, optional
// round-half-up and optional saturation. The whole pipeline advances as one
// when the output register is empty or being drained.
module multiply_const_pipe #(
    parameter int IN_W     = 21,
    parameter int CONST    = 43,
    parameter int CONST_W  = 6,
    parameter int OUT_W    = 30,
    parameter int SHIFT    = 0,
    parameter int ROUND    = 0,
    parameter int SATURATE = 1
) (
    input logic                 clk,
    input logic                 rst,
    multiply_const_pipe_if.slave bus
);
    // Constant split into a low half (bits below H) and a high half.
    localparam int H   = CONST_W / 2;
    localparam int PW  = IN_W + CONST_W;
    localparam int PLW = IN_W + H;
    localparam int PHW = IN_W + CONST_W - H;
    localparam int RW  = PW + 1;
    localparam logic [CONST_W-1:0] CV = CONST_W'(CONST);
    localparam logic [RW-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic           en;
    logic           v1_q, v2_q, ov_q;
    logic [PLW-1:0] pl_c, pl_q;
    logic [PHW-1:0] ph_c, ph_q;
    logic [PW-1:0]  p_q;
    logic [RW-1:0]  r;
    logic [OUT_W-1:0] y_c, y_q;
    logic           sat_c, sat_q;

    assign en           = !ov_q || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = ov_q;
    assign bus.y        = y_q;
    assign bus.sat      = sat_q;

    // Shift-add partial sums for the two halves of the constant.
    always_comb begin
        pl_c = '0;
        ph_c = '0;
        for (int i = 0; i < H; i++) begin
            if (CV[i]) pl_c = pl_c + (PLW'(bus.x) << i);
        end
        for (int i = H; i < CONST_W; i++) begin
            if (CV[i]) ph_c = ph_c + (PHW'(bus.x) << (i - H));
        end
    end

    // Stage valid bits and output register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ov_q  <= 1'b0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (en) begin
            v1_q  <= bus.in_valid;
            v2_q  <= v1_q;
            ov_q  <= v2_q;
            y_q   <= y_c;
            sat_q <= sat_c;
        end
    end

    // Datapath registers for stages 1 and 2; contents under a bubble are don't-care.
    always_ff @(posedge clk) begin
        if (en) begin
            pl_q <= pl_c;
            ph_q <= ph_c;
            p_q  <= PW'(pl_q) + (PW'(ph_q) << H);
        end
    end

    // Rounding offset and fixed-point shift, one spare bit for the carry.
    always_comb begin
        r = (RW'(p_q) + RND) >> SHIFT;
    end

    generate
        if (OUT_W >= RW) begin : g_wide
            // Output can hold any shifted product: no overflow path exists.
            always_comb begin
                y_c        = '0;
                y_c[RW-1:0] = r;
                sat_c      = 1'b0;
            end
        end else begin : g_narrow
            logic ovf;
            // Clamp or wrap when the shifted product exceeds the output width.
            always_comb begin
                ovf   = |r[RW-1:OUT_W];
                sat_c = ovf && (SATURATE != 0);
                y_c   = sat_c ? '1 : r[OUT_W-1:0];
            end
        end
    endgenerate
endmodule

// File: tb/tb_multiply_const_pipe.sv
// Bench for multiply_const_pipe: six parameterisations driven by one shared
// stream, checked against an arithmetic model plus hand-computed literals.
module tb_multiply_const_pipe;
    localparam int IN_W = 21;
    localparam int N    = 6;
    // dut0 default, dut1/2 OUT_W=24 sat/wrap, dut3/4 SHIFT=2 trunc/round, dut5 OUT_W=32
    localparam int P_OUT_W [N] = '{30, 24, 24, 30, 30, 32};
    localparam int P_SHIFT [N] = '{0, 0, 0, 2, 2, 0};
    localparam int P_ROUND [N] = '{0, 0, 0, 0, 1, 0};
    localparam int P_SAT   [N] = '{1, 1, 0, 1, 1, 1};

    typedef struct packed {
        int                  acc;
        logic                lat;
        logic [N-1:0]        lm;
        logic [N-1:0]        ls;
        logic [N-1:0][31:0]  ly;
    } meta_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid  = 1'b0;
    logic [IN_W-1:0] x         = '0;
    logic            out_ready = 1'b1;

    multiply_const_pipe_if #(.IN_W(21), .OUT_W(30)) b0 ();
    multiply_const_pipe_if #(.IN_W(21), .OUT_W(24)) b1 ();
    multiply_const_pipe_if #(.IN_W(21), .OUT_W(24)) b2 ();
    multiply_const_pipe_if #(.IN_W(21), .OUT_W(30)) b3 ();
    multiply_const_pipe_if #(.IN_W(21), .OUT_W(30)) b4 ();
    multiply_const_pipe_if #(.IN_W(21), .OUT_W(32)) b5 ();

    multiply_const_pipe #(.OUT_W(30)) d0 (.clk(clk), .rst(rst), .bus(b0));
    multiply_const_pipe #(.OUT_W(24), .SATURATE(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
    multiply_const_pipe #(.OUT_W(24), .SATURATE(0)) d2 (.clk(clk), .rst(rst), .bus(b2));
    multiply_const_pipe #(.SHIFT(2), .ROUND(0)) d3 (.clk(clk), .rst(rst), .bus(b3));
    multiply_const_pipe #(.SHIFT(2), .ROUND(1)) d4 (.clk(clk), .rst(rst), .bus(b4));
    multiply_const_pipe #(.OUT_W(32)) d5 (.clk(clk), .rst(rst), .bus(b5));

    assign b0.in_valid = in_valid; assign b0.x = x; assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid; assign b1.x = x; assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid; assign b2.x = x; assign b2.out_ready = out_ready;
    assign b3.in_valid = in_valid; assign b3.x = x; assign b3.out_ready = out_ready;
    assign b4.in_valid = in_valid; assign b4.x = x; assign b4.out_ready = out_ready;
    assign b5.in_valid = in_valid; assign b5.x = x; assign b5.out_ready = out_ready;

    logic [31:0] yv  [N];
    logic        ovv [N];
    logic        irv [N];
    logic        sv  [N];
    assign yv[0] = 32'(b0.y); assign ovv[0] = b0.out_valid; assign irv[0] = b0.in_ready; assign sv[0] = b0.sat;
    assign yv[1] = 32'(b1.y); assign ovv[1] = b1.out_valid; assign irv[1] = b1.in_ready; assign sv[1] = b1.sat;
    assign yv[2] = 32'(b2.y); assign ovv[2] = b2.out_valid; assign irv[2] = b2.in_ready; assign sv[2] = b2.sat;
    assign yv[3] = 32'(b3.y); assign ovv[3] = b3.out_valid; assign irv[3] = b3.in_ready; assign sv[3] = b3.sat;
    assign yv[4] = 32'(b4.y); assign ovv[4] = b4.out_valid; assign irv[4] = b4.in_ready; assign sv[4] = b4.sat;
    assign yv[5] = b5.y;      assign ovv[5] = b5.out_valid; assign irv[5] = b5.in_ready; assign sv[5] = b5.sat;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [IN_W-1:0] exp_q[$];
    meta_t           meta_q[$];

    logic [N-1:0][31:0] cur_ly = '0;
    logic [N-1:0]       cur_lm = '0;
    logic [N-1:0]       cur_ls = '0;
    logic               cur_lat = 1'b0;
    int                 rdy_mode = 0;

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_r(int k, logic [IN_W-1:0] xv);
        logic [63:0] p;
        p = 64'(xv) * 64'd43;
        if (P_ROUND[k] != 0 && P_SHIFT[k] > 0) p = p + (64'd1 << (P_SHIFT[k] - 1));
        return p >> P_SHIFT[k];
    endfunction

    function automatic logic [31:0] model_y(int k, logic [IN_W-1:0] xv);
        logic [63:0] r, lim;
        r   = model_r(k, xv);
        lim = 64'd1 << P_OUT_W[k];
        if (r >= lim) return (P_SAT[k] != 0) ? 32'(lim - 1) : 32'(r % lim);
        return 32'(r);
    endfunction

    function automatic logic model_s(int k, logic [IN_W-1:0] xv);
        return (model_r(k, xv) >= (64'd1 << P_OUT_W[k])) && (P_SAT[k] != 0);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, k, cyc, act, exp);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic        prev_stall = 1'b0;
    logic [31:0] prev_y [N];
    logic        prev_s [N];

    initial begin
        logic [IN_W-1:0] xe;
        meta_t m;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                for (int k = 0; k < N; k++)
                    chk("in_ready", k, 32'(irv[k]), 32'(!ovv[k] || out_ready));
                if (prev_stall) begin
                    for (int k = 0; k < N; k++) begin
                        chk("hold_valid", k, 32'(ovv[k]), 32'd1);
                        chk("hold_y", k, yv[k], prev_y[k]);
                        chk("hold_sat", k, 32'(sv[k]), 32'(prev_s[k]));
                    end
                end
                prev_stall = ovv[0] && !out_ready;
                for (int k = 0; k < N; k++) begin
                    prev_y[k] = yv[k];
                    prev_s[k] = sv[k];
                end
                if (ovv[0] && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out cyc=%0d got=%0d want=none", cyc, yv[0]);
                    end else begin
                        xe = exp_q.pop_front();
                        m  = meta_q.pop_front();
                        for (int k = 0; k < N; k++) begin
                            chk("y", k, yv[k], model_y(k, xe));
                            chk("sat", k, 32'(sv[k]), 32'(model_s(k, xe)));
                            if (m.lm[k]) begin
                                chk("lit_y", k, yv[k], m.ly[k]);
                                chk("lit_sat", k, 32'(sv[k]), 32'(m.ls[k]));
                            end
                        end
                        if (m.lat) chk("latency", 0, 32'(cyc - m.acc), 32'd3);
                    end
                end
                if (in_valid && irv[0]) begin
                    m.acc = cyc;
                    m.lat = cur_lat;
                    m.lm  = cur_lm;
                    m.ls  = cur_ls;
                    m.ly  = cur_ly;
                    exp_q.push_back(x);
                    meta_q.push_back(m);
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        logic [3:0] pat;
        int pc;
        pat = 4'b1001;
        pc  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin out_ready = pat[pc % 4]; pc++; end
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_lit(input int a0, input int a1, input int a2, input int a3,
                           input int a4, input int a5, input logic [N-1:0] ls,
                           input logic [N-1:0] lm);
        cur_ly[0] = 32'(a0); cur_ly[1] = 32'(a1); cur_ly[2] = 32'(a2);
        cur_ly[3] = 32'(a3); cur_ly[4] = 32'(a4); cur_ly[5] = 32'(a5);
        cur_ls = ls;
        cur_lm = lm;
    endtask

    task automatic send(input logic [IN_W-1:0] xv);
        int n;
        n = 0;
        in_valid = 1'b1;
        x = xv;
        @(negedge clk);
        while (!irv[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout cyc=%0d got=stalled want=accept", cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 0, 32'(exp_q.size()), 32'd0);
        idle(4);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [IN_W-1:0] xv;
        int sel;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_valid", k, 32'(ovv[k]), 32'd0);
            chk("rst_y", k, yv[k], 32'd0);
            chk("rst_sat", k, 32'(sv[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // consecutive small operands, ready held high
        cur_lat = 1'b1;
        set_lit(0, 0, 0, 0, 0, 0, '0, '1);              send(21'd0);
        set_lit(43, 43, 43, 10, 11, 43, '0, '1);        send(21'd1);
        set_lit(86, 86, 86, 21, 22, 86, '0, '1);        send(21'd2);
        set_lit(430, 430, 430, 107, 108, 430, '0, '1);  send(21'd10);
        wait_drain();

        // all-ones operand: saturation, wrap, rounding at the top of the range
        set_lit(90177493, 16777215, 6291413, 22544373, 22544373, 90177493, 6'b000010, '1);
        send('1);
        wait_drain();

        // backpressure with a 1-0-0-1 out_ready pattern
        cur_lat = 1'b0;
        rdy_mode = 1;
        for (int i = 1; i <= 8; i++) begin
            set_lit(43 * i, 43 * i, 43 * i, 0, 0, 43 * i, '0, 6'b100111);
            send(21'(i));
        end
        wait_drain();

        // reset with three beats in flight
        cur_lat = 1'b1;
        cur_lm  = '0;
        send(21'd100);
        send(21'd200);
        send(21'd300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        meta_q.delete();
        @(negedge clk);
        for (int k = 0; k < N; k++) chk("post_rst_valid", k, 32'(ovv[k]), 32'd0);
        idle(5);
        set_lit(215, 215, 215, 53, 54, 215, '0, '1);
        send(21'd5);
        wait_drain();

        // random operands, ready held high, random gaps
        cur_lm = '0;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            xv  = (sel == 0) ? '1 : (sel == 1) ? '0 : 21'($urandom);
            idle($urandom_range(0, 1));
            send(xv);
        end
        wait_drain();

        // random operands with random backpressure
        cur_lat  = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            xv  = (sel == 0) ? '1 : (sel == 1) ? '0 : 21'($urandom);
            idle($urandom_range(0, 2));
            send(xv);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
